// File: rtl/ddr5_rd_preamble_tracker.sv
// ---------------------------------------------------------------------------
// ddr5_rd_preamble_tracker
//
// Per-lane DQS read-strobe tracker for the DDR5 PHY read data path. Each lane
// watches its sampled DQS for the programmed read preamble, frames the burst
// that follows, checks DQS toggling inside the burst and the postamble after
// it, and reports SEARCH timeouts. A cross-lane pulse marks detections that
// land in the same cycle on every lane.
//
// Ports
//   clk_i              PHY clock, one DQS sample per lane per rising edge
//   reset_n_i          asynchronous active-low reset
//   en_i               tracking enable; low sends every lane to IDLE
//   dqs_sample_i       sampled DQS, bit k = lane k
//   pre_amble_sett_i   preamble pattern select
//   post_amble_sett_i  0: postamble "0", 1: postamble "010"
//   burst_cycles_i     burst length in clocks (0 behaves as 1)
//   timeout_i          SEARCH timeout in cycles (0 disables)
//   err_clr_i          clears the sticky error flags
//   preamble_det_o     1-cycle pulse per lane on preamble match
//   burst_valid_o      high during each lane's burst window
//   aligned_o          1-cycle pulse when all lanes detect together
//   toggle_err_o       sticky: DQS failed to toggle inside the burst
//   postamble_err_o    sticky: postamble mismatch
//   timeout_o          1-cycle pulse on SEARCH timeout
// ---------------------------------------------------------------------------
module ddr5_rd_preamble_tracker #(
    parameter int NUM_LANES = 2,
    parameter int BURST_W   = 5,
    parameter int TMO_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 en_i,
    input  logic [NUM_LANES-1:0] dqs_sample_i,
    input  logic [2:0]           pre_amble_sett_i,
    input  logic                 post_amble_sett_i,
    input  logic [BURST_W-1:0]   burst_cycles_i,
    input  logic [TMO_W-1:0]     timeout_i,
    input  logic                 err_clr_i,
    output logic [NUM_LANES-1:0] preamble_det_o,
    output logic [NUM_LANES-1:0] burst_valid_o,
    output logic                 aligned_o,
    output logic [NUM_LANES-1:0] toggle_err_o,
    output logic [NUM_LANES-1:0] postamble_err_o,
    output logic [NUM_LANES-1:0] timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_BURST, ST_POST} state_t;

    // Preamble pattern, oldest bit leftmost, right-aligned in 8 bits.
    function automatic logic [7:0] pre_pat(input logic [2:0] sel);
        case (sel)
            3'd1:    pre_pat = 8'b0000_0010;
            3'd2:    pre_pat = 8'b0000_1110;
            3'd3:    pre_pat = 8'b0000_0010;
            3'd4:    pre_pat = 8'b0000_1010;
            default: pre_pat = 8'b0000_0010;
        endcase
    endfunction

    function automatic logic [3:0] pre_len(input logic [2:0] sel);
        case (sel)
            3'd1:    pre_len = 4'd4;
            3'd2:    pre_len = 4'd4;
            3'd3:    pre_len = 4'd6;
            3'd4:    pre_len = 4'd8;
            default: pre_len = 4'd2;
        endcase
    endfunction

    function automatic logic [7:0] len_mask(input logic [3:0] len);
        len_mask = 8'hFF >> (4'd8 - len);
    endfunction

    logic [NUM_LANES-1:0] w_match;
    logic                 r_aligned;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        state_t             r_state;
        // Seven bits of history plus the current sample form the 8-bit window.
        logic [6:0]         r_shift;
        logic [3:0]         r_fill;
        logic [TMO_W-1:0]   r_tmo_cnt;
        logic [BURST_W-1:0] r_bcnt;
        logic               r_exp;
        logic [1:0]         r_pidx;
        logic [2:0]         r_pre_sel;
        logic               r_post_sel;
        logic [BURST_W-1:0] r_burst_len;
        logic [TMO_W-1:0]   r_tmo_lim;
        logic               r_det;
        logic               r_bvalid;
        logic               r_tog_err;
        logic               r_post_err;
        logic               r_tmo;

        logic               w_s;
        logic [7:0]         w_cand;
        logic [3:0]         w_fill_nxt;
        logic [TMO_W-1:0]   w_tmo_nxt;
        logic               w_tmo_hit;
        logic               w_tog_bad;
        logic               w_post_bad;
        logic               w_post_last;

        assign w_s        = dqs_sample_i[k];
        assign w_cand     = {r_shift, w_s};
        assign w_fill_nxt = (r_fill == 4'd8) ? 4'd8 : r_fill + 4'd1;
        // The fill requirement keeps cleared zeros out of any match.
        assign w_match[k] = en_i && (r_state == ST_SEARCH)
                         && ((w_cand & len_mask(pre_len(r_pre_sel))) == pre_pat(r_pre_sel))
                         && (w_fill_nxt >= pre_len(r_pre_sel));
        assign w_tmo_nxt  = r_tmo_cnt + TMO_W'(1);
        assign w_tmo_hit  = (w_tmo_nxt == r_tmo_lim);
        // r_exp holds the required burst sample: 1 first, then the inverse of the last one.
        assign w_tog_bad  = en_i && (r_state == ST_BURST) && (w_s != r_exp);
        assign w_post_bad = en_i && (r_state == ST_POST)
                         && (w_s != (r_post_sel && (r_pidx == 2'd1)));
        assign w_post_last = (r_pidx == (r_post_sel ? 2'd2 : 2'd0));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_state     <= ST_IDLE;
                r_shift     <= '0;
                r_fill      <= '0;
                r_tmo_cnt   <= '0;
                r_bcnt      <= '0;
                r_exp       <= 1'b0;
                r_pidx      <= '0;
                r_pre_sel   <= '0;
                r_post_sel  <= 1'b0;
                r_burst_len <= '0;
                r_tmo_lim   <= '0;
                r_det       <= 1'b0;
                r_bvalid    <= 1'b0;
                r_tog_err   <= 1'b0;
                r_post_err  <= 1'b0;
                r_tmo       <= 1'b0;
            end else begin
                r_det    <= 1'b0;
                r_tmo    <= 1'b0;
                r_bvalid <= 1'b0;
                if (!en_i) begin
                    r_state   <= ST_IDLE;
                    r_shift   <= '0;
                    r_fill    <= '0;
                    r_tmo_cnt <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_pre_sel   <= pre_amble_sett_i;
                            r_post_sel  <= post_amble_sett_i;
                            r_burst_len <= burst_cycles_i;
                            r_tmo_lim   <= timeout_i;
                            r_shift     <= '0;
                            r_fill      <= '0;
                            r_tmo_cnt   <= '0;
                            r_state     <= ST_SEARCH;
                        end
                        ST_SEARCH: begin
                            r_shift <= w_cand[6:0];
                            r_fill  <= w_fill_nxt;
                            if (w_match[k]) begin
                                r_det     <= 1'b1;
                                r_state   <= ST_BURST;
                                r_bcnt    <= (r_burst_len == '0) ? BURST_W'(1) : r_burst_len;
                                r_exp     <= 1'b1;
                                r_tmo_cnt <= '0;
                            end else if (r_tmo_lim != '0) begin
                                if (w_tmo_hit) begin
                                    r_tmo     <= 1'b1;
                                    r_tmo_cnt <= '0;
                                    r_fill    <= '0;
                                end else begin
                                    r_tmo_cnt <= w_tmo_nxt;
                                end
                            end
                        end
                        ST_BURST: begin
                            r_bvalid <= 1'b1;
                            r_exp    <= ~w_s;
                            r_bcnt   <= r_bcnt - BURST_W'(1);
                            if (r_bcnt == BURST_W'(1)) begin
                                r_state <= ST_POST;
                                r_pidx  <= '0;
                            end
                        end
                        ST_POST: begin
                            r_pidx <= r_pidx + 2'd1;
                            if (w_post_last) begin
                                r_state   <= ST_SEARCH;
                                r_shift   <= '0;
                                r_fill    <= '0;
                                r_tmo_cnt <= '0;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
                // A new error in the clear cycle wins over the clear.
                if (w_tog_bad)      r_tog_err <= 1'b1;
                else if (err_clr_i) r_tog_err <= 1'b0;
                if (w_post_bad)     r_post_err <= 1'b1;
                else if (err_clr_i) r_post_err <= 1'b0;
            end
        end

        assign preamble_det_o[k]  = r_det;
        assign burst_valid_o[k]   = r_bvalid;
        assign toggle_err_o[k]    = r_tog_err;
        assign postamble_err_o[k] = r_post_err;
        assign timeout_o[k]       = r_tmo;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_aligned <= 1'b0;
        else            r_aligned <= &w_match;
    end

    assign aligned_o = r_aligned;

endmodule

// File: doc/ddr5_rd_preamble_tracker.md
# ddr5_rd_preamble_tracker

Multi-lane, parametrised read-strobe tracker for the DDR5 PHY read data manager. Each lane samples its DQS, finds the programmed read preamble, then frames the burst. It checks DQS toggling and the postamble during the burst, and flags timeouts. It sits between the DQS sampling stage and the read-data capture FIFO, which it drives with per-lane burst-valid windows and a cross-lane alignment pulse.

## Interface
Parameters:
- NUM_LANES, 2, number of independent DQS lanes (byte lanes), ≥1
- BURST_W, 5, width of burst cycle count
- TMO_W, 8, width of preamble timeout counter

Ports:
- clk_i  in  1  PHY clock, single clock domain. One DQS sample per lane per rising edge.
- reset_n_i  in  1  reset, asynchronous and active-low
- en_i  in  1  tracking enable. Low forces every lane to IDLE synchronously.
- dqs_sample_i  in  NUM_LANES  sampled DQS, bit k = lane k
- pre_amble_sett_i  in  3  preamble select: 000 "10", 001 "0010", 010 "1110", 011 "000010", 100 "00001010", others "10". Oldest bit is leftmost.
- post_amble_sett_i  in  1  0: 0.5tCK postamble, expect "0"; 1: 1.5tCK postamble, expect "010"
- burst_cycles_i  in  BURST_W  burst length in clocks, 0 treated as 1
- timeout_i  in  TMO_W  max SEARCH cycles without detection, 0 = timeout disabled
- err_clr_i  in  1  clears the sticky error flags
- preamble_det_o  out  NUM_LANES  1-cycle pulse per lane on preamble match
- burst_valid_o  out  NUM_LANES  high during the lane's burst window
- aligned_o  out  1  1-cycle pulse when all lanes assert preamble_det_o in the same cycle
- toggle_err_o  out  NUM_LANES  sticky; DQS failed to toggle inside the burst
- postamble_err_o  out  NUM_LANES  sticky; postamble mismatch
- timeout_o  out  NUM_LANES  1-cycle pulse on SEARCH timeout

## Operation
- Each lane has its own FSM: IDLE, SEARCH, BURST, POST.
- **Settings latch:** pre_amble_sett_i, post_amble_sett_i, burst_cycles_i and timeout_i are latched per lane on the IDLE→SEARCH transition. Changes mid-operation are ignored until the lane next leaves IDLE.
- **IDLE:** 8-bit shift register and fill counter are cleared. The lane moves to SEARCH on the next edge while en_i=1.
- **SEARCH:** the new sample is shifted in at LSB each cycle. The fill counter saturates at 8.
  - Match = the low L bits of {shift_reg, new sample} equal the pattern of length L, AND fill ≥ L including the current sample. Cleared zeros therefore never form part of a match.
  - On match: preamble_det_o pulses and the lane goes to BURST with its burst counter loaded to the latched burst_cycles.
  - If timeout ≠ 0: the timeout counter increments every SEARCH cycle. On reaching the latched timeout, timeout_o pulses, the counter and fill reset, and the lane stays in SEARCH.
- **BURST:** burst_valid_o=1.
  - The first burst sample must be 1. Each subsequent sample must differ from the previous one. Any violation sets toggle_err_o[k] and the burst continues.
  - After burst_cycles samples the lane goes to POST.
- **POST:** compares 1 sample (setting 0) or 3 samples (setting 1) against the expected postamble. Any mismatch sets postamble_err_o[k]. The lane then goes to SEARCH with fill=0 and the timeout counter restarted, so back-to-back reads work.
- **aligned_o** = AND of preamble_det_o across all lanes, registered in the same cycle as the detect pulses.
- **Sticky errors** clear only on err_clr_i=1 or reset. If a new error occurs in the same cycle as err_clr_i, the set wins.
- **en_i low:** in any state, the lane goes to IDLE on the next edge. burst_valid_o drops that edge, no pulse outputs fire, and sticky errors are retained.

## Timing
- Reset: every output is 0, all FSMs are in IDLE, and all counters and shift registers are 0.
- en_i rising at edge E: the lane is in SEARCH from edge E+1, and the first sample is taken at edge E+1.
- The last preamble sample taken at edge N gives preamble_det_o high during N→N+1, with burst_valid_o high from N+1.
- burst_valid_o stays high for exactly burst_cycles clocks. The first burst sample is taken at edge N+1.
- POST occupies 1 or 3 clocks immediately after the burst. postamble_err_o is set at the edge after the mismatching sample.
- The earliest next preamble sample is at the edge following the last POST sample.
- Lanes are fully independent. Different lanes may be in different states, and aligned_o requires the detections to occur in the same cycle.

## Test plan
- Reset mid-burst (assert reset_n_i while burst_valid_o=1) -> all outputs 0 asynchronously, no pulse after release, next detection needs fresh samples.
- Setting 001, lane0 DQS 0,0,1,0 starting at edge E+1 -> preamble_det_o[0] pulses after edge E+4. Check that 1,0 alone (fill=2) does not detect.
- Setting 100, burst_cycles 4, post 1, DQS 00001010 | 1010 | 010 -> det pulse, burst_valid 4 clocks, no errors, lane back in SEARCH.
- Same as the previous case but burst 1011 and postamble 011 -> toggle_err_o and postamble_err_o set and held; err_clr_i for one cycle clears both.
- Two lanes, setting 000, lane1 delayed one cycle -> no aligned_o. Both lanes in phase -> aligned_o one pulse.
- timeout 5, DQS held 0 -> timeout_o pulses every 5 SEARCH cycles. Drop en_i during BURST -> burst_valid_o low the next edge.
